readout_sequencer: RTL and testbench
====================================

Name: readout_sequencer

Overview:
Controls the readout path of the spectrogram extractor. When the overflow condition rises, it walks the 16-entry data mux (RTC word first, then channels 1..15). For each entry it loads the PISO register and shifts out 12 bits, pausing whenever the downstream `ready` is low. After channel 15 it pulses the counter-clear output and returns to idle. It takes over the sequencing role between the overflow logic, the 16:1 mux and the PISO register.

Parameters:
NUM_CH, 16, number of mux entries read per frame (entry 0 = RTC word)
DATA_W, 12, bits shifted per entry
SEL_W, 4, width of mux select
FCNT_W, 8, width of frame counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
ovf  input  1  global overflow level from counters/RTC, asynchronous to clk
ready  input  1  downstream can accept a serial bit this cycle
select  output  SEL_W  mux select, index of entry being read
SL  output  1  1 = parallel load PISO this cycle, 0 = shift/hold
shift_en  output  1  PISO shifts one bit this cycle (SL=0 and ready=1 in SHIFT)
frame_start  output  1  one-cycle pulse coincident with first LOAD of a frame
rst_counters  output  1  one-cycle pulse clearing channel/RTC counters
busy  output  1  high in every state except IDLE
frame_cnt  output  FCNT_W  completed frames, wraps 255->0
missed_trigger  output  1  sticky: trigger arrived while one was already pending

Behaviour:
- Reset (reset=0, async) forces state IDLE and zeros every output: select=0, SL=0, shift_en=0, frame_start=0, rst_counters=0, busy=0, frame_cnt=0, missed_trigger=0. It also clears the pending flag and the synchronizer flops.
- `ovf` passes through a 2-flop synchronizer, then a rising-edge detector. A trigger is one clk after the synchronized edge (3 cycles after the `ovf` rise).
- States:
  - IDLE
    - On trigger or pending=1: go to LOAD, select=0, frame_start=1, clear pending.
  - LOAD (one cycle)
    - SL=1, shift_en=0.
    - If ready=0, hold in LOAD with SL=1; a repeated load is harmless.
    - Go to SHIFT with bit counter = 0.
  - SHIFT
    - SL=0, shift_en=ready.
    - Bit counter increments only when ready=1.
    - After the DATA_W-th accepted bit (counter = DATA_W-1 and ready=1):
      - if select=NUM_CH-1, go to CLEAR;
      - otherwise select++ and go to LOAD.
  - CLEAR (one cycle)
    - rst_counters=1, frame_cnt++ (modulo 2^FCNT_W), then go to IDLE.
- Select changes only on the SHIFT->LOAD transition and is stable for the whole LOAD/SHIFT of an entry.
- With ready held at 1, one frame takes NUM_CH*(1+DATA_W)+1 = 209 cycles from the first LOAD to the end of CLEAR.
- Trigger while busy:
  - If pending=0, set pending; the next frame starts on the cycle after CLEAR (IDLE lasts 1 cycle).
  - If pending=1 already, set missed_trigger (sticky until reset).
- Trigger in the same cycle as CLEAR counts as "while busy".
- `ovf` still high after CLEAR does not retrigger; only a new rising edge triggers.
- ready=0 for any number of cycles never drops or duplicates a shifted bit; the bit counter and select are frozen.
- `reset` asserted mid-frame: immediate IDLE, with no rst_counters pulse and no frame_cnt increment.

Optional Feature:
CH_MASK_EN:
- Defined: adds input `ch_mask` [NUM_CH-1:0]. Entries with mask bit 1 are skipped; the sequencer advances select to the next unmasked index without entering LOAD for the skipped entries.
- Bit 0 (RTC) is ignored; the RTC word is always read.
- If entry NUM_CH-1 is masked, the last unmasked entry goes directly to CLEAR.
- `ch_mask` is sampled once at frame start and held for the frame.
- Undefined: no port, all NUM_CH entries are read.

Test Plan:
- Basic frame: reset release, ready=1, pulse ovf.
  - frame_start 3 cycles after the ovf rise.
  - 16 LOAD pulses, select 0..15, 192 shift_en cycles.
  - rst_counters once; frame_cnt=1; 209 busy cycles.
- Backpressure: ready=0 for 5 cycles at bit 6 of entry 3. Total shift_en stays 192, select stays 3 during the stall, and the frame is 214 cycles.
- Trigger during frame:
  - Second ovf edge at entry 8: the next frame starts 1 cycle after CLEAR, frame_cnt=2, missed_trigger=0.
  - A third edge in the same frame sets missed_trigger=1.
- Reset mid-frame at entry 10: all outputs 0 immediately, no rst_counters pulse, frame_cnt unchanged, next ovf edge starts at select=0.
- Wrap: run 256 frames and check frame_cnt returns to 0.
- CH_MASK_EN with ch_mask=16'h8006: entries 1, 2 and 15 are skipped, 13 LOADs, 156 shift_en cycles, CLEAR directly after entry 14.

Source files
------------

// File: rtl/readout_sequencer.sv
// readout_sequencer: walks the 16:1 readout mux after each overflow event,
// loading the PISO register per entry and shifting DATA_W bits out under
// downstream ready backpressure, then pulses the counter clear.
// Optional feature macro: CH_MASK_EN (adds ch_mask input to skip entries).
`timescale 1ns/1ps

module readout_sequencer #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 12,
  parameter int SEL_W  = 4,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ovf,
  input  logic              ready,
`ifdef CH_MASK_EN
  input  logic [NUM_CH-1:0] ch_mask,
`endif
  output logic [SEL_W-1:0]  select,
  output logic              SL,
  output logic              shift_en,
  output logic              frame_start,
  output logic              rst_counters,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              missed_trigger
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_sync3;
  logic              w_trig;

  logic [SEL_W-1:0]  r_select;
  logic [BC_W-1:0]   r_bit_cnt;
  logic              r_frame_start;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_pending;
  logic              r_missed;

  logic              w_start;
  logic              w_last_bit;
  logic              w_has_next;
  logic [SEL_W-1:0]  w_next_sel;
  logic [NUM_CH-1:0] w_mask_eff;

  // ovf is asynchronous: two flops for metastability, a third for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= ovf;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_trig     = r_sync2 & ~r_sync3;
  assign w_start    = (r_state == S_IDLE) && (w_trig || r_pending);
  assign w_last_bit = (r_state == S_SHIFT) && ready &&
                      (r_bit_cnt == BC_W'(DATA_W - 1));

`ifdef CH_MASK_EN
  logic [NUM_CH-1:0] r_mask;

  // Mask is captured once per frame so mid-frame changes cannot skew the walk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask <= '0;
    end else if (w_start) begin
      r_mask <= ch_mask;
    end
  end

  // Entry 0 (RTC word) is always read regardless of its mask bit
  assign w_mask_eff = {r_mask[NUM_CH-1:1], 1'b0};
`else
  assign w_mask_eff = '0;
`endif

  // Find the lowest unmasked entry above the current select
  always_comb begin
    w_has_next = 1'b0;
    w_next_sel = r_select;
    for (int i = NUM_CH - 1; i > 0; i--) begin
      if ((i > int'(r_select)) && !w_mask_eff[i]) begin
        w_has_next = 1'b1;
        w_next_sel = SEL_W'(i);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic; LOAD holds until ready so the load is never lost
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_LOAD;
      S_LOAD:  if (ready) w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_last_bit) begin
          w_next = w_has_next ? S_LOAD : S_CLEAR;
        end
      end
      S_CLEAR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    SL           = 1'b0;
    shift_en     = 1'b0;
    rst_counters = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      S_IDLE:  busy = 1'b0;
      S_LOAD:  SL = 1'b1;
      S_SHIFT: shift_en = ready;
      S_CLEAR: rst_counters = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Entry select and bit counter; both freeze while ready is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_select  <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_start) begin
        r_select <= '0;
      end else if (w_last_bit && w_has_next) begin
        r_select <= w_next_sel;
      end
      if (r_state == S_LOAD) begin
        r_bit_cnt <= '0;
      end else if ((r_state == S_SHIFT) && ready) begin
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BC_W'(1);
      end
    end
  end

  // Frame bookkeeping: start pulse, completed-frame count, pending/missed triggers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
      r_pending     <= 1'b0;
      r_missed      <= 1'b0;
    end else begin
      r_frame_start <= w_start;
      if (r_state == S_CLEAR) begin
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      end
      if (w_start) begin
        // A fresh edge arriving together with a queued one stays queued
        r_pending <= w_trig && r_pending;
      end else if (w_trig) begin
        if (!r_pending) begin
          r_pending <= 1'b1;
        end else begin
          r_missed <= 1'b1;
        end
      end
    end
  end

  assign select         = r_select;
  assign frame_start    = r_frame_start;
  assign frame_cnt      = r_frame_cnt;
  assign missed_trigger = r_missed;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed self-checking bench for readout_sequencer.
`timescale 1ns/1ps

module tb_readout_sequencer;

  localparam int NUM_CH = 16;
  localparam int DATA_W = 12;
  localparam int SEL_W  = 4;
  localparam int FCNT_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              ovf;
  logic              ready;
`ifdef CH_MASK_EN
  logic [NUM_CH-1:0] ch_mask;
`endif
  logic [SEL_W-1:0]  select;
  logic              SL;
  logic              shift_en;
  logic              frame_start;
  logic              rst_counters;
  logic              busy;
  logic [FCNT_W-1:0] frame_cnt;
  logic              missed_trigger;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_load, n_shift, n_busy, n_clr, n_fs;
  int sel_log [32];

  readout_sequencer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W), .FCNT_W(FCNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ovf            (ovf),
    .ready          (ready),
`ifdef CH_MASK_EN
    .ch_mask        (ch_mask),
`endif
    .select         (select),
    .SL             (SL),
    .shift_en       (shift_en),
    .frame_start    (frame_start),
    .rst_counters   (rst_counters),
    .busy           (busy),
    .frame_cnt      (frame_cnt),
    .missed_trigger (missed_trigger)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_load = 0; n_shift = 0; n_busy = 0; n_clr = 0; n_fs = 0;
    for (int i = 0; i < 32; i++) sel_log[i] = -1;
  endtask

  // One clock: sample at the falling edge (inputs settled), return 1ns after rise
  task automatic cyc();
    @(negedge clk);
    if (SL) begin
      if (n_load < 32) sel_log[n_load] = int'(select);
      n_load++;
    end
    if (shift_en)     n_shift++;
    if (busy)         n_busy++;
    if (rst_counters) n_clr++;
    if (frame_start)  n_fs++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_idle(input string tag);
    int g;
    g = 0;
    while (busy === 1'b1 && g < 2000) begin
      cyc();
      g++;
    end
    chk({tag, " idle reached"}, busy, 0);
  endtask

  // ovf rise, then frame_start must appear exactly on the third rising edge
  task automatic trigger_frame(input string tag);
    ovf = 1'b1;
    cyc();
    cyc();
    chk({tag, " no early start"}, frame_start, 0);
    cyc();
    chk({tag, " frame_start"}, frame_start, 1);
    chk({tag, " first SL"}, SL, 1);
    chk({tag, " first select"}, select, 0);
    ovf = 1'b0;
  endtask

  initial begin
    int ok;
    reset = 1'b0;
    ovf   = 1'b0;
    ready = 1'b1;
`ifdef CH_MASK_EN
    ch_mask = '0;
`endif
    clr_counts();

    // ---- power-on reset values
    #12;
    chk("rst select", select, 0);
    chk("rst SL", SL, 0);
    chk("rst shift_en", shift_en, 0);
    chk("rst frame_start", frame_start, 0);
    chk("rst rst_counters", rst_counters, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst missed", missed_trigger, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) cyc();

    // ---- reset in the middle of a frame at entry 10
    trigger_frame("midrst");
    repeat (130) cyc();
    chk("midrst at entry10 select", select, 10);
    chk("midrst at entry10 SL", SL, 1);
    #3 reset = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst select", select, 0);
    chk("midrst SL", SL, 0);
    chk("midrst shift_en", shift_en, 0);
    chk("midrst rst_counters", rst_counters, 0);
    chk("midrst frame_cnt", frame_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    clr_counts();
    repeat (20) cyc();
    chk("midrst no clear pulse", n_clr, 0);
    chk("midrst stays idle", n_busy, 0);

    // ---- basic frame with ready held high
    clr_counts();
    trigger_frame("basic");
    run_to_idle("basic");
    chk("basic busy cycles", n_busy, 209);
    chk("basic loads", n_load, 16);
    chk("basic shifts", n_shift, 192);
    chk("basic clears", n_clr, 1);
    chk("basic starts", n_fs, 1);
    ok = 1;
    for (int i = 0; i < 16; i++) if (sel_log[i] != i) ok = 0;
    chk("basic select order", ok, 1);
    chk("basic frame_cnt", frame_cnt, 1);
    chk("basic missed", missed_trigger, 0);

    // ---- backpressure: 5 stalled cycles at bit 6 of entry 3
    clr_counts();
    trigger_frame("bp");
    repeat (46) cyc();
    chk("bp select at stall", select, 3);
    chk("bp in shift", SL, 0);
    chk("bp shifting before stall", shift_en, 1);
    ready = 1'b0;
    #1;
    chk("bp shift_en gated", shift_en, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp select frozen", select, 3);
    end
    ready = 1'b1;
    run_to_idle("bp");
    chk("bp busy cycles", n_busy, 214);
    chk("bp shifts", n_shift, 192);
    chk("bp loads", n_load, 16);
    chk("bp frame_cnt", frame_cnt, 2);

    // ---- triggers while busy: pending, then missed
    clr_counts();
    trigger_frame("trigA");
    repeat (104) cyc();
    chk("trigA at entry8", select, 8);
    ovf = 1'b1;
    repeat (4) cyc();
    ovf = 1'b0;
    repeat (4) cyc();
    chk("trigA missed after 2nd edge", missed_trigger, 0);
    run_to_idle("trigA");
    chk("trigA frame_cnt", frame_cnt, 3);
    chk("trigA idle SL", SL, 0);
    cyc();
    chk("trigB auto start", frame_start, 1);
    chk("trigB auto SL", SL, 1);
    chk("trigB select", select, 0);
    chk("trigB missed", missed_trigger, 0);
    repeat (26) cyc();
    ovf = 1'b1;
    repeat (4) cyc();
    ovf = 1'b0;
    repeat (4) cyc();
    chk("trigB one queued", missed_trigger, 0);
    repeat (70) cyc();
    ovf = 1'b1;
    repeat (4) cyc();
    ovf = 1'b0;
    repeat (4) cyc();
    chk("trigB missed set", missed_trigger, 1);
    run_to_idle("trigB");
    chk("trigB frame_cnt", frame_cnt, 4);
    cyc();
    chk("trigC auto start", frame_start, 1);
    run_to_idle("trigC");
    chk("trigC frame_cnt", frame_cnt, 5);
    repeat (10) cyc();
    chk("trigC no further frame", busy, 0);
    chk("trigC missed sticky", missed_trigger, 1);

`ifdef CH_MASK_EN
    // ---- masked entries 1, 2 and 15
    ch_mask = 16'h8006;
    clr_counts();
    trigger_frame("mask");
    ch_mask = '0;
    run_to_idle("mask");
    chk("mask loads", n_load, 13);
    chk("mask shifts", n_shift, 156);
    chk("mask busy cycles", n_busy, 170);
    chk("mask second entry", sel_log[1], 3);
    chk("mask last entry", sel_log[12], 14);
    chk("mask clears", n_clr, 1);
    chk("mask frame_cnt", frame_cnt, 6);
`endif

    // ---- frame counter wrap after 256 frames
    #3 reset = 1'b0;
    #1;
    chk("wrap pre frame_cnt", frame_cnt, 0);
    chk("wrap pre missed cleared", missed_trigger, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) cyc();
    for (int f = 0; f < 256; f++) begin
      clr_counts();
      trigger_frame("wrap");
      run_to_idle("wrap");
      if (f == 254) chk("wrap frame_cnt 255", frame_cnt, 255);
    end
    chk("wrap frame_cnt 0", frame_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
